// File: rtl/day04_input_rom.sv
// -----------------------------------------------------------------------------
// day04_input_rom
// Byte buffer for the day-04 puzzle input. A file is streamed in over a
// valid/ready byte interface (FILL). The byte flagged in_last freezes the
// buffer, which is then served read-only to the solver core by address (SERVE).
// A read at or beyond the stored length returns rom_valid = 0, which the core
// uses as its end-of-file marker.
//
// Parameters
//   N_ADDR_BITS  address width; rom_addr/byte_count are N_ADDR_BITS+1 bits
//   DEPTH        byte capacity (DEPTH <= 2**N_ADDR_BITS)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous restart of the fill (memory is kept)
//   in_data/in_valid/in_last/in_ready   input byte stream
//   rom_addr/rom_data/rom_valid         combinational read port
//   loaded              buffer complete and serving
//   start               one-cycle pulse on the first SERVE cycle
//   byte_count          bytes written so far (FILL) / file length (SERVE)
//   overflow            sticky: a byte was dropped because the buffer was full
//
// Build option
//   DAY04_INPUT_ROM_CR_STRIP_EN  when defined, 8'h0D bytes are consumed but
//                                neither stored nor counted.
// -----------------------------------------------------------------------------
module day04_input_rom #(
    parameter int N_ADDR_BITS = 16,
    parameter int DEPTH       = 32768
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic [N_ADDR_BITS:0]   rom_addr,
    output logic [7:0]             rom_data,
    output logic                   rom_valid,
    output logic                   loaded,
    output logic                   start,
    output logic [N_ADDR_BITS:0]   byte_count,
    output logic                   overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [N_ADDR_BITS:0] DEPTH_V = (N_ADDR_BITS + 1)'(DEPTH);

    typedef enum logic {FILL, SERVE} state_t;

    state_t                 state;
    logic [N_ADDR_BITS:0]   wr_ptr;
    logic [N_ADDR_BITS:0]   length;
    logic [7:0]             mem [DEPTH];

    logic take;      // handshake that is not overridden by clear
    logic keep;      // byte is to be stored (not a stripped CR)
    logic has_room;
    logic wr_en;

`ifdef DAY04_INPUT_ROM_CR_STRIP_EN
    assign keep = (in_data != 8'h0D);
`else
    assign keep = 1'b1;
`endif

    assign in_ready = (state == FILL);
    assign take     = in_valid & in_ready & ~clear;
    assign has_room = (wr_ptr < DEPTH_V);
    assign wr_en    = take & keep & has_room;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            wr_ptr   <= '0;
            length   <= '0;
            loaded   <= 1'b0;
            start    <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= FILL;
            wr_ptr   <= '0;
            length   <= '0;
            loaded   <= 1'b0;
            start    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            start <= 1'b0;
            if (take) begin
                if (keep) begin
                    if (has_room) wr_ptr   <= wr_ptr + 1'b1;
                    else          overflow <= 1'b1;
                end
                if (in_last) begin
                    // Length includes the final byte only if it was actually stored.
                    length <= wr_ptr + {{N_ADDR_BITS{1'b0}}, wr_en};
                    state  <= SERVE;
                    loaded <= 1'b1;
                    start  <= 1'b1;
                end
            end
        end
    end

    // Storage is not reset: a clear or rst only forgets the length.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    // length <= DEPTH, so any address that passes this compare is in range,
    // including the extra top address bit's wrap region.
    assign rom_valid  = (state == SERVE) && (rom_addr < length);
    assign rom_data   = rom_valid ? mem[rom_addr[AW-1:0]] : 8'h00;
    assign byte_count = (state == SERVE) ? length : wr_ptr;

endmodule

// File: tb/tb_day04_input_rom.sv
module tb_day04_input_rom;
    localparam int NA = 16, DA = 32768;
    localparam int NB = 3,  DB = 4;
`ifdef DAY04_INPUT_ROM_CR_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_valid = 1'b0, in_last = 1'b0;
    logic in_ready_a, in_ready_b;
    logic [NA:0] rom_addr_a = '0;
    logic [NB:0] rom_addr_b = '0;
    logic [7:0]  rom_data_a, rom_data_b;
    logic rom_valid_a, rom_valid_b, loaded_a, loaded_b, start_a, start_b;
    logic [NA:0] byte_count_a;
    logic [NB:0] byte_count_b;
    logic overflow_a, overflow_b;

    int checks = 0, failures = 0;

    // Reference model: the stored file as a queue per buffer size.
    logic [7:0] qa[$], qb[$];
    bit ovf_a, ovf_b, m_serve;

    always #5 clk = ~clk;

    day04_input_rom #(.N_ADDR_BITS(NA), .DEPTH(DA)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .rom_valid(rom_valid_a), .loaded(loaded_a), .start(start_a),
        .byte_count(byte_count_a), .overflow(overflow_a));

    day04_input_rom #(.N_ADDR_BITS(NB), .DEPTH(DB)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .rom_valid(rom_valid_b), .loaded(loaded_b), .start(start_b),
        .byte_count(byte_count_b), .overflow(overflow_b));

    task automatic m_clear();
        qa.delete(); qb.delete();
        ovf_a = 0; ovf_b = 0; m_serve = 0;
    endtask

    task automatic m_push(input logic [7:0] b, input logic last);
        if (!m_serve) begin
            if (!(STRIP && b == 8'h0D)) begin
                if (qa.size() < DA) qa.push_back(b); else ovf_a = 1;
                if (qb.size() < DB) qb.push_back(b); else ovf_b = 1;
            end
            if (last) m_serve = 1;
        end
    endtask

    // Called at a negedge; returns at the negedge after the capturing posedge.
    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1'b1; in_data = b; in_last = last;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        m_push(b, last);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_clear();
    endtask

    task automatic test_reset();
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_a); end
        checks++; if (loaded_a !== 1'b0 || loaded_b !== 1'b0) begin failures++; $display("FAIL reset_loaded got=%b/%b exp=0", loaded_a, loaded_b); end
        checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start_a); end
        checks++; if (byte_count_a !== 0 || byte_count_b !== 0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0", byte_count_a, byte_count_b); end
        checks++; if (overflow_a !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_a); end
        rom_addr_a = '0; #1;
        checks++; if (rom_valid_a !== 1'b0 || rom_data_a !== 8'h00) begin failures++; $display("FAIL reset_rom got=%b/%h exp=0/00", rom_valid_a, rom_data_a); end
    endtask

    task automatic test_directed();
        logic [7:0] s [6];
        s = '{8'h40, 8'h2E, 8'h0A, 8'h2E, 8'h40, 8'h0A};
        for (int i = 0; i < 6; i++) send(s[i], i == 5);
        checks++; if (start_a !== 1'b1 || loaded_a !== 1'b1) begin failures++; $display("FAIL dir_start got=%b/%b exp=1/1", start_a, loaded_a); end
        checks++; if (byte_count_a !== 6) begin failures++; $display("FAIL dir_count got=%0d exp=6", byte_count_a); end
        checks++; if (overflow_b !== 1'b1 || byte_count_b !== 4) begin failures++; $display("FAIL dir_ovf got=%b/%0d exp=1/4", overflow_b, byte_count_b); end
        checks++; if (overflow_a !== 1'b0 || in_ready_a !== 1'b0) begin failures++; $display("FAIL dir_ovf_a got=%b rdy=%b exp=0/0", overflow_a, in_ready_a); end
        @(negedge clk);
        checks++; if (start_a !== 1'b0 || loaded_a !== 1'b1) begin failures++; $display("FAIL dir_start_once got=%b/%b exp=0/1", start_a, loaded_a); end
        for (int ad = 0; ad < 8; ad++) begin
            logic ev; logic [7:0] ed;
            rom_addr_a = ad[NA:0]; #1;
            ev = (ad < 6); ed = ev ? s[ad] : 8'h00;
            checks++; if (rom_valid_a !== ev || rom_data_a !== ed) begin failures++; $display("FAIL dir_read_a addr=%0d got=%b/%h exp=%b/%h", ad, rom_valid_a, rom_data_a, ev, ed); end
        end
        for (int ad = 0; ad < 16; ad++) begin
            logic ev; logic [7:0] ed;
            rom_addr_b = ad[NB:0]; #1;
            ev = (ad < 4); ed = ev ? s[ad] : 8'h00;
            checks++; if (rom_valid_b !== ev || rom_data_b !== ed) begin failures++; $display("FAIL dir_read_b addr=%0d got=%b/%h exp=%b/%h", ad, rom_valid_b, rom_data_b, ev, ed); end
        end
        @(negedge clk);
    endtask

    task automatic test_clear_serve();
        do_clear();
        checks++; if (loaded_a !== 1'b0 || in_ready_a !== 1'b1 || byte_count_a !== 0) begin failures++; $display("FAIL clr_state got ld=%b rdy=%b cnt=%0d exp=0/1/0", loaded_a, in_ready_a, byte_count_a); end
        checks++; if (overflow_b !== 1'b0 || start_a !== 1'b0) begin failures++; $display("FAIL clr_flags got ovf=%b st=%b exp=0/0", overflow_b, start_a); end
        send(8'h2E, 1'b1);
        checks++; if (byte_count_a !== 1) begin failures++; $display("FAIL clr_count got=%0d exp=1", byte_count_a); end
        rom_addr_a = 1; #1;
        checks++; if (rom_valid_a !== 1'b0) begin failures++; $display("FAIL clr_addr1 got=%b exp=0", rom_valid_a); end
        rom_addr_a = 0; #1;
        checks++; if (rom_valid_a !== 1'b1 || rom_data_a !== 8'h2E) begin failures++; $display("FAIL clr_addr0 got=%b/%h exp=1/2e", rom_valid_a, rom_data_a); end
        @(negedge clk);
    endtask

    task automatic test_async_rst();
        do_clear();
        for (int i = 0; i < 3; i++) send(8'h40, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (in_ready_a !== 1'b1 || byte_count_a !== 0 || loaded_a !== 1'b0) begin failures++; $display("FAIL async_rst got rdy=%b cnt=%0d ld=%b exp=1/0/0", in_ready_a, byte_count_a, loaded_a); end
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic test_clear_collision();
        send(8'h2E, 1'b0);
        send(8'h2E, 1'b0);
        in_valid = 1'b1; in_data = 8'h40; in_last = 1'b1; clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
        m_clear();
        checks++; if (byte_count_a !== 0 || loaded_a !== 1'b0) begin failures++; $display("FAIL coll_count got=%0d ld=%b exp=0/0", byte_count_a, loaded_a); end
        send(8'h2E, 1'b1);
        rom_addr_a = 0; #1;
        checks++; if (byte_count_a !== 1 || rom_data_a !== 8'h2E) begin failures++; $display("FAIL coll_after got=%0d/%h exp=1/2e", byte_count_a, rom_data_a); end
        @(negedge clk);
    endtask

    task automatic test_cr();
        do_clear();
        send(8'h40, 1'b0); send(8'h0D, 1'b0); send(8'h0A, 1'b1);
        checks++; if (byte_count_a !== (STRIP ? 2 : 3)) begin failures++; $display("FAIL cr_count got=%0d exp=%0d", byte_count_a, STRIP ? 2 : 3); end
        rom_addr_a = 1; #1;
        checks++; if (rom_data_a !== (STRIP ? 8'h0A : 8'h0D)) begin failures++; $display("FAIL cr_mem1 got=%h exp=%h", rom_data_a, STRIP ? 8'h0A : 8'h0D); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            int n;
            do_clear();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
                if ($urandom_range(0, 2) == 0) @(negedge clk);
                send(b, i == n - 1);
                if (i != n - 1) begin
                    checks++; if (byte_count_a !== qa.size() || byte_count_b !== qb.size() || rom_valid_a !== 1'b0) begin failures++; $display("FAIL rnd_fill r=%0d got=%0d/%0d v=%b exp=%0d/%0d", r, byte_count_a, byte_count_b, rom_valid_a, qa.size(), qb.size()); end
                end
            end
            checks++; if (start_a !== 1'b1 || start_b !== 1'b1) begin failures++; $display("FAIL rnd_start r=%0d got=%b/%b exp=1", r, start_a, start_b); end
            // Non-last bytes offered while serving must be ignored.
            for (int i = 0; i < 2; i++) send(8'($urandom_range(0, 255)), 1'b0);
            checks++; if (byte_count_a !== qa.size() || byte_count_b !== qb.size()) begin failures++; $display("FAIL rnd_count r=%0d got=%0d/%0d exp=%0d/%0d", r, byte_count_a, byte_count_b, qa.size(), qb.size()); end
            checks++; if (overflow_a !== ovf_a || overflow_b !== ovf_b || loaded_a !== m_serve) begin failures++; $display("FAIL rnd_flags r=%0d got=%b/%b/%b exp=%b/%b/%b", r, overflow_a, overflow_b, loaded_a, ovf_a, ovf_b, m_serve); end
            for (int k = 0; k < 6; k++) begin
                int aa, ab; logic eva, evb; logic [7:0] eda, edb;
                aa = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 12) : $urandom_range(0, (1 << (NA + 1)) - 1);
                ab = $urandom_range(0, 15);
                rom_addr_a = aa[NA:0]; rom_addr_b = ab[NB:0]; #1;
                eva = m_serve && (aa < qa.size()); eda = eva ? qa[aa] : 8'h00;
                evb = m_serve && (ab < qb.size()); edb = evb ? qb[ab] : 8'h00;
                checks++; if (rom_valid_a !== eva || rom_data_a !== eda) begin failures++; $display("FAIL rnd_read_a r=%0d addr=%0d got=%b/%h exp=%b/%h", r, aa, rom_valid_a, rom_data_a, eva, eda); end
                checks++; if (rom_valid_b !== evb || rom_data_b !== edb) begin failures++; $display("FAIL rnd_read_b r=%0d addr=%0d got=%b/%h exp=%b/%h", r, ab, rom_valid_b, rom_data_b, evb, edb); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        m_clear();
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_clear_serve();
        test_async_rst();
        test_clear_collision();
        test_cr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end
endmodule
